// File: rtl/id_ex_seg_reg.sv
// ID/EX pipeline segment register with flush, stall and self-inserted load-use bubbles.
// Also keeps a saturating count of the bubbles inserted into EX.
module id_ex_seg_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        JalD,
    input  logic        JalrD,
    input  logic        MemToRegD,
    input  logic        LoadNpcD,
    input  logic        AluSrc1D,
    input  logic [2:0]  RegWriteD,
    input  logic [2:0]  BranchTypeD,
    input  logic [3:0]  MemWriteD,
    input  logic [3:0]  AluContrlD,
    input  logic [1:0]  AluSrc2D,
    input  logic [1:0]  RegReadD,
    input  logic [31:0] PCD,
    input  logic [31:0] RegOut1D,
    input  logic [31:0] RegOut2D,
    input  logic [31:0] ImmD,
    input  logic [4:0]  RdD,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    output logic        JalE,
    output logic        JalrE,
    output logic        MemToRegE,
    output logic        LoadNpcE,
    output logic        AluSrc1E,
    output logic [2:0]  RegWriteE,
    output logic [2:0]  BranchTypeE,
    output logic [3:0]  MemWriteE,
    output logic [3:0]  AluContrlE,
    output logic [1:0]  AluSrc2E,
    output logic [1:0]  RegReadE,
    output logic [31:0] PCE,
    output logic [31:0] RegOut1E,
    output logic [31:0] RegOut2E,
    output logic [31:0] ImmE,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic        ValidE,
    output logic        LoadUseStallD,
    output logic [15:0] BubbleCnt
);

    localparam logic [2:0] NOREGWRITE = 3'b000;
    localparam logic [2:0] NOBRANCH   = 3'b000;

    logic rs1Hit;
    logic rs2Hit;
    logic bubble;

    // A load in EX whose destination is read by the instruction in ID must wait one cycle.
    assign rs1Hit        = RegReadD[1] & (Rs1D == RdE);
    assign rs2Hit        = RegReadD[0] & (Rs2D == RdE);
    assign LoadUseStallD = ValidE & MemToRegE & (RdE != 5'd0) & (rs1Hit | rs2Hit);
    assign bubble        = FlushE | LoadUseStallD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            JalE        <= 1'b0;
            JalrE       <= 1'b0;
            MemToRegE   <= 1'b0;
            LoadNpcE    <= 1'b0;
            AluSrc1E    <= 1'b0;
            RegWriteE   <= NOREGWRITE;
            BranchTypeE <= NOBRANCH;
            MemWriteE   <= 4'b0000;
            AluContrlE  <= 4'b0000;
            AluSrc2E    <= 2'b00;
            RegReadE    <= 2'b00;
            PCE         <= 32'd0;
            RegOut1E    <= 32'd0;
            RegOut2E    <= 32'd0;
            ImmE        <= 32'd0;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            ValidE      <= 1'b0;
            BubbleCnt   <= 16'd0;
        end else if (bubble) begin
            JalE        <= 1'b0;
            JalrE       <= 1'b0;
            MemToRegE   <= 1'b0;
            LoadNpcE    <= 1'b0;
            AluSrc1E    <= 1'b0;
            RegWriteE   <= NOREGWRITE;
            BranchTypeE <= NOBRANCH;
            MemWriteE   <= 4'b0000;
            AluContrlE  <= 4'b0000;
            AluSrc2E    <= 2'b00;
            RegReadE    <= 2'b00;
            PCE         <= 32'd0;
            RegOut1E    <= 32'd0;
            RegOut2E    <= 32'd0;
            ImmE        <= 32'd0;
            RdE         <= 5'd0;
            Rs1E        <= 5'd0;
            Rs2E        <= 5'd0;
            ValidE      <= 1'b0;
            // Saturate so a long-running count never wraps back to a small value.
            if (BubbleCnt != 16'hFFFF) begin
                BubbleCnt <= BubbleCnt + 16'd1;
            end
        end else if (!StallE) begin
            JalE        <= JalD;
            JalrE       <= JalrD;
            MemToRegE   <= MemToRegD;
            LoadNpcE    <= LoadNpcD;
            AluSrc1E    <= AluSrc1D;
            RegWriteE   <= RegWriteD;
            BranchTypeE <= BranchTypeD;
            MemWriteE   <= MemWriteD;
            AluContrlE  <= AluContrlD;
            AluSrc2E    <= AluSrc2D;
            RegReadE    <= RegReadD;
            PCE         <= PCD;
            RegOut1E    <= RegOut1D;
            RegOut2E    <= RegOut2D;
            ImmE        <= ImmD;
            RdE         <= RdD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            ValidE      <= 1'b1;
        end
    end

endmodule
